// File: rtl/load_store_unit.sv
// M-stage load/store unit: aligns, issues and tracks one memory access at a time,
// stalling the pipeline until MemAck or a bus-error timeout.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        DoneM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_sat;
    logic [31:0]   rdata_q;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;

    logic        access, is_byte, is_half, is_word, misalign_cond;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Size decode: 00 byte, 01 half, anything else (incl. 011/110/111) word.
    assign access        = MemReadM | MemWriteM;
    assign is_byte       = (Funct3M[1:0] == 2'b00);
    assign is_half       = (Funct3M[1:0] == 2'b01);
    assign is_word       = ~is_byte & ~is_half;
    assign misalign_cond = (is_half & DataAdrM[0]) | (is_word & (|DataAdrM[1:0]));
    assign cnt_sat       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign dbg_state     = state;

    always_comb begin
        byte_en = 4'b1111;
        wdata   = WriteDataM;
        if (is_byte) begin
            byte_en = 4'b0001 << DataAdrM[1:0];
            wdata   = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            byte_en = 4'b0011 << DataAdrM[1:0];
            wdata   = {2{WriteDataM[15:0]}};
        end
    end

    // Handshake: MemReq is held with stable request fields until the cycle MemAck=1
    // is sampled; MemAck outside REQ carries no meaning and is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access && !misalign_cond) state_next = REQ;
            REQ: begin
                if (MemAck)                  state_next = DONE;
                else if (cnt_sat == CNT_MAX) state_next = ERR;
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational status is gated by reset so everything reads 0 while it is held.
    assign MisalignM = reset & access & (state == IDLE) & misalign_cond;
    assign StallM    = reset & access & ((state == IDLE) | (state == REQ)) & ~MisalignM;
    assign DoneM     = reset & (MisalignM | (state == DONE) | (state == ERR));
    assign BusErrM   = reset & (state == ERR);

    assign rd_byte = rdata_q[{lane_q, 3'b000} +: 8];
    assign rd_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        ReadDataM = 32'h0;
        if (state == DONE) begin
            case (f3_q[1:0])
                2'b00:   ReadDataM = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
                2'b01:   ReadDataM = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
                default: ReadDataM = rdata_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            MemAddr   <= 32'h0;
            MemByteEn <= 4'h0;
            MemWData  <= 32'h0;
            rdata_q   <= 32'h0;
            lane_q    <= 2'b00;
            f3_q      <= 3'b000;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (state_next == REQ) begin
                        MemReq    <= 1'b1;
                        MemWe     <= MemWriteM;
                        MemAddr   <= {DataAdrM[31:2], 2'b00};
                        MemByteEn <= byte_en;
                        MemWData  <= wdata;
                        lane_q    <= DataAdrM[1:0];
                        f3_q      <= Funct3M;
                    end
                end
                REQ: begin
                    if (MemAck) rdata_q <= MemRData;
                    else        cnt     <= cnt_sat;
                    if (state_next != REQ) begin
                        MemReq <= 1'b0;
                        MemWe  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver tasks push expected requests and completions,
// a monitor pops and compares them whenever the DUT raises MemReq or DoneM.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] DataAdrM = 32'h0, WriteDataM = 32'h0;
    logic [31:0] ReadDataM;
    logic        StallM, DoneM, MisalignM, BusErrM;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic [31:0] MemRData = 32'h0;
    logic        MemAck;
    logic [1:0]  dbg_state;

    logic        resp_ack = 1'b0, manual_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    int          ack_delay = -1;
    int          req_cycles = 0;

    int checks = 0;
    int fails  = 0;

    logic [68:0] req_q[$];
    logic [42:0] exp_q[$];

    assign MemAck = resp_ack | manual_ack;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .DoneM(DoneM),
        .MisalignM(MisalignM), .BusErrM(BusErrM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemByteEn(MemByteEn), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] rq(input logic we, input logic [31:0] addr,
                                       input logic [3:0] be, input logic [31:0] wd);
        return {we, addr, be, wd};
    endfunction

    // {StallM, BusErrM, MisalignM, ReadDataM, stall cycles before DoneM}
    function automatic logic [42:0] dn(input logic berr, input logic mis,
                                       input logic [31:0] rd, input int stalls);
        return {1'b0, berr, mis, rd, 8'(stalls)};
    endfunction

    // memory responder: acks during the (ack_delay+1)-th REQ cycle
    initial forever begin
        @(posedge clk);
        #1;
        MemRData = mem_rdata;
        if (MemReq) begin
            resp_ack = (req_cycles == ack_delay);
            req_cycles++;
        end else begin
            resp_ack   = 1'b0;
            req_cycles = 0;
        end
    end

    // monitor / scoreboard
    initial begin
        int          stall_cnt;
        logic        in_req;
        logic [68:0] held, cur, e;
        logic [42:0] dcur, de;
        stall_cnt = 0;
        in_req    = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_cnt = 0;
                in_req    = 1'b0;
            end else begin
                if (MemReq) begin
                    cur = rq(MemWe, MemAddr, MemByteEn, MemWData);
                    if (!in_req) begin
                        if (req_q.size() == 0) begin
                            check("unexpected_req", cur, 69'h0);
                        end else begin
                            e = req_q.pop_front();
                            check("req", cur, e);
                        end
                        held = cur;
                    end else begin
                        check("req_stable", cur, held);
                    end
                    in_req = 1'b1;
                end else begin
                    in_req = 1'b0;
                end
                if (DoneM) begin
                    dcur = {StallM, BusErrM, MisalignM, ReadDataM, 8'(stall_cnt)};
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 69'(dcur), 69'h0);
                    end else begin
                        de = exp_q.pop_front();
                        check("done", 69'(dcur), 69'(de));
                    end
                    stall_cnt = 0;
                end else if (StallM) begin
                    stall_cnt++;
                end
            end
        end
    end

    // driver: present one M-stage access and hold it until DoneM
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay,
                             input logic exp_req, input logic [68:0] req_exp,
                             input logic [42:0] done_exp);
        bit seen;
        @(posedge clk);
        #1;
        if (exp_req) req_q.push_back(req_exp);
        exp_q.push_back(done_exp);
        mem_rdata  = rdata;
        ack_delay  = delay;
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        DataAdrM   = addr;
        WriteDataM = wd;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (DoneM) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_wait: got no DoneM expected DoneM within 60 cycles");
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        ack_delay = -1;
    endtask

    task automatic check_quiet(input string name);
        check(name, 69'({StallM, DoneM, MisalignM, BusErrM, MemReq, MemWe, MemByteEn, dbg_state}), 69'h0);
        check({name, "_addr"}, 69'(MemAddr), 69'h0);
        check({name, "_wdata"}, 69'(MemWData), 69'h0);
        check({name, "_rdata"}, 69'(ReadDataM), 69'h0);
    endtask

    initial begin
        // reset held with an aligned load presented: every output must stay 0
        reset    = 1'b0;
        MemReadM = 1'b1;
        Funct3M  = 3'b010;
        DataAdrM = 32'h20;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        MemReadM = 1'b0;
        #1 reset = 1'b1;

        // lw, ack in first REQ cycle
        do_access(1, 0, 3'b010, 32'h20, 32'h0, 32'h0409_2A16, 0, 1,
                  rq(0, 32'h20, 4'b1111, 32'h0), dn(0, 0, 32'h0409_2A16, 2));
        // sb to lane 3
        do_access(0, 1, 3'b000, 32'h63, 32'h0000_00AB, 32'h0, 0, 1,
                  rq(1, 32'h60, 4'b1000, 32'hABAB_ABAB), dn(0, 0, 32'h0, 2));
        // lb / lbu sign vs zero extension
        do_access(1, 0, 3'b000, 32'h61, 32'h0, 32'h0000_8000, 0, 1,
                  rq(0, 32'h60, 4'b0010, 32'h0), dn(0, 0, 32'hFFFF_FF80, 2));
        do_access(1, 0, 3'b100, 32'h61, 32'h0, 32'h0000_8000, 0, 1,
                  rq(0, 32'h60, 4'b0010, 32'h0), dn(0, 0, 32'h0000_0080, 2));
        // misaligned lw
        do_access(1, 0, 3'b010, 32'h22, 32'h0, 32'h0, 0, 0, 69'h0, dn(0, 1, 32'h0, 0));
        // lh upper half with slow ack, then lhu
        do_access(1, 0, 3'b001, 32'h62, 32'h0, 32'h8001_0000, 2, 1,
                  rq(0, 32'h60, 4'b1100, 32'h0), dn(0, 0, 32'hFFFF_8001, 4));
        do_access(1, 0, 3'b101, 32'h62, 32'h0, 32'h8001_0000, 0, 1,
                  rq(0, 32'h60, 4'b1100, 32'h0), dn(0, 0, 32'h0000_8001, 2));
        // sh and sw
        do_access(0, 1, 3'b001, 32'h06, 32'h1234_BEEF, 32'h0, 0, 1,
                  rq(1, 32'h04, 4'b1100, 32'hBEEF_BEEF), dn(0, 0, 32'h0, 2));
        do_access(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1, 1,
                  rq(1, 32'h10, 4'b1111, 32'hDEAD_BEEF), dn(0, 0, 32'h0, 3));
        // read+write together is a store
        do_access(1, 1, 3'b000, 32'h01, 32'h0000_005A, 32'h0, 0, 1,
                  rq(1, 32'h00, 4'b0010, 32'h5A5A_5A5A), dn(0, 0, 32'h0, 2));
        // reserved funct3 decode as word
        do_access(1, 0, 3'b111, 32'h41, 32'h0, 32'h0, 0, 0, 69'h0, dn(0, 1, 32'h0, 0));
        do_access(1, 0, 3'b011, 32'h44, 32'h0, 32'hCAFE_F00D, 0, 1,
                  rq(0, 32'h44, 4'b1111, 32'h0), dn(0, 0, 32'hCAFE_F00D, 2));
        // misaligned lh, lb lane 2
        do_access(1, 0, 3'b001, 32'h03, 32'h0, 32'h0, 0, 0, 69'h0, dn(0, 1, 32'h0, 0));
        do_access(1, 0, 3'b000, 32'h02, 32'h0, 32'h12FE_3456, 0, 1,
                  rq(0, 32'h00, 4'b0100, 32'h0), dn(0, 0, 32'hFFFF_FFFE, 2));
        // timeout: 15 REQ cycles then bus error
        do_access(1, 0, 3'b010, 32'h80, 32'h0, 32'h5555_5555, -1, 1,
                  rq(0, 32'h80, 4'b1111, 32'h0), dn(1, 0, 32'h0, 16));
        // ack in the 15th REQ cycle beats the timeout
        do_access(1, 0, 3'b010, 32'h84, 32'h0, 32'h1122_3344, 14, 1,
                  rq(0, 32'h84, 4'b1111, 32'h0), dn(0, 0, 32'h1122_3344, 16));

        // reset mid-access, then a stray ack after release
        @(posedge clk);
        #1;
        req_q.push_back(rq(0, 32'h30, 4'b1111, 32'h0));
        ack_delay = -1;
        MemReadM  = 1'b1;
        Funct3M   = 3'b010;
        DataAdrM  = 32'h30;
        repeat (3) @(negedge clk);
        #1;
        reset    = 1'b0;
        MemReadM = 1'b0;
        @(negedge clk);
        check_quiet("mid_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        mem_rdata  = 32'h7777_7777;
        manual_ack = 1'b1;
        @(posedge clk);
        #1 manual_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("stray_ack");

        repeat (3) @(negedge clk);
        check("queues_empty", 69'(req_q.size() + exp_q.size()), 69'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
